// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the fetch/LSU RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam logic [1:0] OPLEN_WORD = 2'b11;
    localparam int         DEF_ADDR_W = 25;
    localparam int         DEF_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational 2-way round-robin picker (bit 0 fetch, bit 1 data).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic       gnt_valid,
    output owner_t     gnt_owner
);

    always_comb begin
        gnt_valid = |req;
        gnt_owner = OWN_FETCH;
        if (req == 2'b11) begin
            gnt_owner = (last == OWN_DATA) ? OWN_FETCH : OWN_DATA;
        end else if (req[1]) begin
            gnt_owner = OWN_DATA;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single-ported internal RAM between instruction fetch
//               and load/store. Optional WAIT timeout via macro ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_oplen,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_oplen,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_result,
    output logic              busy
);

    state_t            r_state, w_nxt_state;
    owner_t            r_last_owner, w_nxt_last_owner;
    owner_t            w_gnt_owner;
    logic              w_gnt_valid;
    logic              w_timeout;

    logic              w_nxt_mem_enable, w_nxt_mem_we;
    logic [ADDR_W-1:0] w_nxt_mem_addr;
    logic [1:0]        w_nxt_mem_oplen;
    logic [DATA_W-1:0] w_nxt_mem_data;
    logic              w_nxt_if_valid, w_nxt_if_err, w_nxt_d_valid, w_nxt_d_err;
    logic [DATA_W-1:0] w_nxt_if_rdata, w_nxt_d_rdata;

    rr_pick2 u_pick (
        .req       ({d_req, if_req}),
        .last      (r_last_owner),
        .gnt_valid (w_gnt_valid),
        .gnt_owner (w_gnt_owner)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned      c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_wait_cnt;

    // Held at zero outside WAIT so every WAIT entry starts counting from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state != WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == WAIT) && (r_wait_cnt == c_CNT_LAST);
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout            = 1'b0;
`endif

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_last_owner = r_last_owner;
        w_nxt_mem_enable = 1'b0;
        w_nxt_mem_addr   = mem_addr;
        w_nxt_mem_oplen  = mem_oplen;
        w_nxt_mem_we     = mem_we;
        w_nxt_mem_data   = mem_data;
        w_nxt_if_valid   = 1'b0;
        w_nxt_if_rdata   = if_rdata;
        w_nxt_if_err     = 1'b0;
        w_nxt_d_valid    = 1'b0;
        w_nxt_d_rdata    = d_rdata;
        w_nxt_d_err      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_nxt_state      = WAIT;
                    w_nxt_last_owner = w_gnt_owner;
                    w_nxt_mem_enable = 1'b1;
                    if (w_gnt_owner == OWN_FETCH) begin
                        w_nxt_mem_addr  = if_addr;
                        w_nxt_mem_oplen = OPLEN_WORD;
                        w_nxt_mem_we    = 1'b0;
                        w_nxt_mem_data  = '0;
                    end else begin
                        w_nxt_mem_addr  = d_addr;
                        w_nxt_mem_oplen = d_oplen;
                        w_nxt_mem_we    = d_we;
                        w_nxt_mem_data  = d_wdata;
                    end
                end
            end
            WAIT: begin
                // A real completion in the timeout cycle takes priority.
                if (mem_valid || w_timeout) begin
                    w_nxt_state = DONE;
                    if (r_last_owner == OWN_FETCH) begin
                        w_nxt_if_valid = 1'b1;
                        w_nxt_if_rdata = mem_valid ? mem_result : '0;
                        w_nxt_if_err   = !mem_valid;
                    end else begin
                        w_nxt_d_valid  = 1'b1;
                        w_nxt_d_rdata  = mem_valid ? mem_result : '0;
                        w_nxt_d_err    = !mem_valid;
                    end
                end
            end
            DONE:    w_nxt_state = IDLE;
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_owner <= OWN_DATA;
            mem_enable   <= 1'b0;
            mem_addr     <= '0;
            mem_oplen    <= '0;
            mem_we       <= 1'b0;
            mem_data     <= '0;
            if_valid     <= 1'b0;
            if_rdata     <= '0;
            if_err       <= 1'b0;
            d_valid      <= 1'b0;
            d_rdata      <= '0;
            d_err        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_last_owner <= w_nxt_last_owner;
            mem_enable   <= w_nxt_mem_enable;
            mem_addr     <= w_nxt_mem_addr;
            mem_oplen    <= w_nxt_mem_oplen;
            mem_we       <= w_nxt_mem_we;
            mem_data     <= w_nxt_mem_data;
            if_valid     <= w_nxt_if_valid;
            if_rdata     <= w_nxt_if_rdata;
            if_err       <= w_nxt_if_err;
            d_valid      <= w_nxt_d_valid;
            d_rdata      <= w_nxt_d_rdata;
            d_err        <= w_nxt_d_err;
            busy         <= (w_nxt_state != IDLE);
        end
    end

endmodule
`default_nettype wire
